// File: rtl/piranha_plant_ctrl.sv
// ---------------------------------------------------------------------------
// piranha_plant_ctrl
//   Piranha-plant enemy controller. The plant cycles through
//   hide -> rise -> exposed -> sink. It steps once per frame_tick.
//   Emergence is held off while the player stands near the pipe.
//   A fireball hit kills the plant. The sprite is clipped at the pipe lip.
//   Rendering is combinational from the registered position, so it adds no
//   cycles of latency.
//
// Ports
//   Clk, Reset            clock; synchronous active-high reset
//   frame_tick            one-cycle strobe per video frame
//   DrawX, DrawY          pixel currently being drawn
//   start_x, start_y      plant centre when fully hidden
//   level_num             current room
//   plant_level_num       room that owns this plant
//   player_x              Mario centre X
//   hit                   one-cycle fireball-hit pulse
//   is_piranha            pixel belongs to the plant
//   piranha_address       sprite ROM address
//   piranha_X_Pos/_Y_Pos  plant centre
//   piranha_health        1 = alive
//   piranha_state         FSM state
//
// Optional feature macro: PIRANHA_BITE_ANIM_EN
//   When defined, a two-frame bite animation is enabled. The frame toggles
//   every 8 ticks while the plant is visible. Frame 1 addresses the second
//   half of the sprite sheet.
// ---------------------------------------------------------------------------
module piranha_plant_ctrl #(
    parameter int SPRITE_W    = 18,
    parameter int SPRITE_H    = 36,
    parameter int RISE_H      = 36,
    parameter int SPEED       = 1,
    parameter int HIDE_FRAMES = 50,
    parameter int SHOW_FRAMES = 50,
    parameter int PROX_X      = 24,
    parameter int ADDR_W      = 11,
    parameter int OFFSCREEN_X = 800
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        start_x,
    input  logic [9:0]        start_y,
    input  logic [2:0]        level_num,
    input  logic [2:0]        plant_level_num,
    input  logic [9:0]        player_x,
    input  logic              hit,
    output logic              is_piranha,
    output logic [ADDR_W-1:0] piranha_address,
    output logic [9:0]        piranha_X_Pos,
    output logic [9:0]        piranha_Y_Pos,
    output logic              piranha_health,
    output logic [2:0]        piranha_state
);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_HIDDEN  = 3'd1;
    localparam logic [2:0] S_RISING  = 3'd2;
    localparam logic [2:0] S_EXPOSED = 3'd3;
    localparam logic [2:0] S_SINKING = 3'd4;
    localparam logic [2:0] S_DEAD    = 3'd5;

    localparam int TW = 16;
    localparam logic [9:0]    OFF_X = 10'(OFFSCREEN_X);
    localparam logic [TW-1:0] HIDE_LAST = TW'(HIDE_FRAMES - 1);
    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_FRAMES - 1);

    logic [2:0]    r_state, w_state_n;
    logic [9:0]    r_x, w_x_n;
    logic [9:0]    r_y, w_y_n;
    logic [TW-1:0] r_timer, w_timer_n;
    logic          r_health, w_health_n;
    logic          r_hit_pend;

    logic w_active, w_hit_eff, w_far;
    logic signed [10:0] w_sy, w_top, w_cur_y, w_y_up, w_y_dn, w_dx, w_adx;

    assign w_active  = (r_state == S_RISING) || (r_state == S_EXPOSED) ||
                       (r_state == S_SINKING);
    // A hit arriving on the tick cycle itself still counts on that tick.
    assign w_hit_eff = r_hit_pend | hit;

    assign w_sy    = $signed({1'b0, start_y});
    assign w_top   = w_sy - $signed(11'(RISE_H));
    assign w_cur_y = $signed({1'b0, r_y});
    assign w_y_up  = w_cur_y - $signed(11'(SPEED));
    assign w_y_dn  = w_cur_y + $signed(11'(SPEED));
    assign w_dx    = $signed({1'b0, player_x}) - $signed({1'b0, start_x});
    assign w_adx   = (w_dx < 0) ? -w_dx : w_dx;
    assign w_far   = w_adx > $signed(11'(PROX_X));

    always_comb begin
        w_state_n  = r_state;
        w_x_n      = r_x;
        w_y_n      = r_y;
        w_timer_n  = r_timer;
        w_health_n = r_health;
        if (level_num != plant_level_num) begin
            w_state_n = S_OFF;
            w_x_n     = OFF_X;
            w_y_n     = 10'd0;
            w_timer_n = '0;
        end else if (w_hit_eff && w_active) begin
            w_state_n  = S_DEAD;
            w_health_n = 1'b0;
            w_x_n      = OFF_X;
        end else begin
            case (r_state)
                S_OFF: begin
                    // Respawn on every room entry.
                    w_state_n  = S_HIDDEN;
                    w_x_n      = start_x;
                    w_y_n      = start_y;
                    w_timer_n  = '0;
                    w_health_n = 1'b1;
                end
                S_HIDDEN: begin
                    // The timer saturates, so the plant pops up as soon as
                    // the player walks away.
                    if (r_timer != HIDE_LAST) begin
                        w_timer_n = r_timer + 1'b1;
                    end else if (w_far) begin
                        w_state_n = S_RISING;
                        w_timer_n = '0;
                    end
                end
                S_RISING: begin
                    if (w_y_up <= w_top) begin
                        w_y_n     = w_top[9:0];
                        w_state_n = S_EXPOSED;
                        w_timer_n = '0;
                    end else begin
                        w_y_n = w_y_up[9:0];
                    end
                end
                S_EXPOSED: begin
                    if (r_timer == SHOW_LAST) begin
                        w_state_n = S_SINKING;
                        w_timer_n = '0;
                    end else begin
                        w_timer_n = r_timer + 1'b1;
                    end
                end
                S_SINKING: begin
                    if (w_y_dn >= w_sy) begin
                        w_y_n     = start_y;
                        w_state_n = S_HIDDEN;
                        w_timer_n = '0;
                    end else begin
                        w_y_n = w_y_dn[9:0];
                    end
                end
                default: ;  // DEAD: left only through a level mismatch
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_OFF;
            r_x        <= OFF_X;
            r_y        <= 10'd0;
            r_timer    <= '0;
            r_health   <= 1'b1;
            r_hit_pend <= 1'b0;
        end else if (frame_tick) begin
            r_state    <= w_state_n;
            r_x        <= w_x_n;
            r_y        <= w_y_n;
            r_timer    <= w_timer_n;
            r_health   <= w_health_n;
            r_hit_pend <= 1'b0;
        end else if (hit) begin
            r_hit_pend <= 1'b1;
        end
    end

    logic [ADDR_W-1:0] w_frame_add;
`ifdef PIRANHA_BITE_ANIM_EN
    logic [2:0] r_bite_cnt;
    logic       r_bite;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bite_cnt <= 3'd0;
            r_bite     <= 1'b0;
        end else if (frame_tick) begin
            if (w_state_n == S_HIDDEN) begin
                r_bite_cnt <= 3'd0;
                r_bite     <= 1'b0;
            end else if (w_active) begin
                r_bite_cnt <= r_bite_cnt + 3'd1;
                if (r_bite_cnt == 3'd7) r_bite <= ~r_bite;
            end
        end
    end
    assign w_frame_add = r_bite ? ADDR_W'(SPRITE_W * SPRITE_H) : '0;
`else
    assign w_frame_add = '0;
`endif

    logic signed [10:0] w_px, w_py;
    logic w_in_box, w_unclipped;
    assign w_px = $signed({1'b0, DrawX}) - $signed({1'b0, r_x}) + $signed(11'(SPRITE_W / 2));
    assign w_py = $signed({1'b0, DrawY}) - $signed({1'b0, r_y}) + $signed(11'(SPRITE_H / 2));
    assign w_in_box = (w_px >= 0) && (w_px < $signed(11'(SPRITE_W))) &&
                      (w_py >= 0) && (w_py < $signed(11'(SPRITE_H)));
    // Hide whatever part of the plant is still inside the pipe.
    assign w_unclipped = $signed({1'b0, DrawY}) < (w_sy - $signed(11'(SPRITE_H / 2)));

    assign is_piranha      = w_in_box && w_active && w_unclipped;
    assign piranha_address = is_piranha ?
        (ADDR_W'(w_px) + ADDR_W'(w_py) * ADDR_W'(SPRITE_W) + w_frame_add) : '0;

    assign piranha_X_Pos  = r_x;
    assign piranha_Y_Pos  = r_y;
    assign piranha_health = r_health;
    assign piranha_state  = r_state;

endmodule

// File: tb/tb_piranha_plant_ctrl.sv
module tb_piranha_plant_ctrl;
    localparam int ADDR_W = 11;
    localparam int SX = 300, SY = 435;

    logic              Clk = 1'b0;
    logic              Reset, frame_tick, hit;
    logic [9:0]        DrawX, DrawY, start_x, start_y, player_x;
    logic [2:0]        level_num, plant_level_num;
    logic              is_piranha, piranha_health;
    logic [ADDR_W-1:0] piranha_address;
    logic [9:0]        piranha_X_Pos, piranha_Y_Pos;
    logic [2:0]        piranha_state;

    piranha_plant_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .DrawX(DrawX), .DrawY(DrawY), .start_x(start_x), .start_y(start_y),
        .level_num(level_num), .plant_level_num(plant_level_num),
        .player_x(player_x), .hit(hit),
        .is_piranha(is_piranha), .piranha_address(piranha_address),
        .piranha_X_Pos(piranha_X_Pos), .piranha_Y_Pos(piranha_Y_Pos),
        .piranha_health(piranha_health), .piranha_state(piranha_state)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0, n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the plant state, advanced once per applied tick.
    int m_st, m_x, m_y, m_tm, m_hl, m_hp;

    typedef struct { int st; int x; int y; int hl; } st_exp_t;
    typedef struct { int is; int addr; } px_exp_t;
    st_exp_t sb_st[$];
    px_exp_t sb_px[$];

    function automatic void m_reset();
        m_st = 0; m_x = 800; m_y = 0; m_tm = 0; m_hl = 1; m_hp = 0;
    endfunction

    function automatic void m_step();
        int adx;
        adx = int'(player_x) - int'(start_x);
        if (adx < 0) adx = -adx;
        if (level_num != plant_level_num) begin
            m_st = 0; m_x = 800; m_y = 0; m_tm = 0;
        end else if (m_hp != 0 && (m_st == 2 || m_st == 3 || m_st == 4)) begin
            m_st = 5; m_hl = 0; m_x = 800;
        end else begin
            case (m_st)
                0: begin m_st = 1; m_x = start_x; m_y = start_y; m_tm = 0; m_hl = 1; end
                1: begin
                    if (m_tm < 49) m_tm++;
                    else if (adx > 24) begin m_st = 2; m_tm = 0; end
                end
                2: begin
                    m_y = m_y - 1;
                    if (m_y <= int'(start_y) - 36) begin
                        m_y = int'(start_y) - 36; m_st = 3; m_tm = 0;
                    end
                end
                3: begin
                    if (m_tm == 49) begin m_st = 4; m_tm = 0; end
                    else m_tm++;
                end
                4: begin
                    m_y = m_y + 1;
                    if (m_y >= int'(start_y)) begin
                        m_y = start_y; m_st = 1; m_tm = 0;
                    end
                end
                default: ;
            endcase
        end
        m_hp = 0;
    endfunction

    task automatic tick();
        st_exp_t e;
        @(negedge Clk);
        frame_tick = 1'b1;
        m_step();
        sb_st.push_back('{m_st, m_x, m_y, m_hl});
        @(posedge Clk);
        #1 frame_tick = 1'b0;
        e = sb_st.pop_front();
        chk("state",  piranha_state,  e.st);
        chk("x_pos",  piranha_X_Pos,  e.x);
        chk("y_pos",  piranha_Y_Pos,  e.y);
        chk("health", piranha_health, e.hl);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pix(input int dx, input int dy, input int e_is, input int e_addr);
        px_exp_t e;
        @(negedge Clk);
        DrawX = 10'(dx); DrawY = 10'(dy);
        sb_px.push_back('{e_is, e_addr});
        #1;
        e = sb_px.pop_front();
        chk("is_piranha", is_piranha, e.is);
        chk("address", piranha_address, e.addr);
    endtask

    task automatic pulse_hit();
        @(negedge Clk);
        hit = 1'b1;
        @(posedge Clk);
        #1 hit = 1'b0;
        m_hp = 1;
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; hit = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0;
        start_x = 10'(SX); start_y = 10'(SY);
        level_num = 3'd2; plant_level_num = 3'd2; player_x = 10'd100;
        m_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_state",  piranha_state, 0);
        chk("rst_x",      piranha_X_Pos, 800);
        chk("rst_y",      piranha_Y_Pos, 0);
        chk("rst_health", piranha_health, 1);
        chk("rst_is",     is_piranha, 0);
        chk("rst_addr",   piranha_address, 0);
        @(negedge Clk) Reset = 1'b0;

        // Spawn into HIDDEN; plant is invisible everywhere.
        tick();
        chk("spawn_state", piranha_state, 1);
        for (int yy = 395; yy <= 440; yy += 15)
            for (int xx = 285; xx <= 315; xx += 10)
                pix(xx, yy, 0, 0);

        // Full cycle with the player far away.
        ticks(50);
        chk("rise_entry", piranha_state, 2);
        ticks(36);
        chk("exp_entry", piranha_state, 3);
        chk("exp_y", piranha_Y_Pos, 399);
        pix(291, 381, 1, 0);
        pix(308, 416, 1, 647);
        pix(309, 381, 0, 0);
        pix(290, 381, 0, 0);
        ticks(50);
        chk("sink_entry", piranha_state, 4);
        ticks(36);
        chk("hid_entry", piranha_state, 1);
        chk("hid_y", piranha_Y_Pos, 435);

        // Player close to the pipe: emergence inhibited.
        player_x = 10'd310;
        ticks(250);
        chk("prox_hold", piranha_state, 1);
        player_x = 10'd200;
        tick();
        chk("prox_release", piranha_state, 2);

        // Pipe-lip clip while rising.
        ticks(15);
        chk("rise_y420", piranha_Y_Pos, 420);
        pix(300, 417, 0, 0);
        pix(300, 416, 1, 9 + 14 * 18);

        // Leave and re-enter the room.
        level_num = 3'd3;
        tick();
        chk("off_state", piranha_state, 0);
        level_num = 3'd2;
        tick();
        chk("reenter_state", piranha_state, 1);

        // Fireball hit mid-EXPOSED, between ticks.
        ticks(50 + 36 + 10);
        chk("pre_hit", piranha_state, 3);
        pulse_hit();
        tick();
        chk("dead_state", piranha_state, 5);
        chk("dead_health", piranha_health, 0);
        chk("dead_x", piranha_X_Pos, 800);
        pix(300, 400, 0, 0);
        ticks(5);

        // Respawn, then a hit while hidden is ignored.
        level_num = 3'd3;
        tick();
        chk("off_health_hold", piranha_health, 0);
        level_num = 3'd2;
        tick();
        chk("respawn_health", piranha_health, 1);
        pulse_hit();
        tick();
        chk("hidden_hit_ign", piranha_state, 1);
        ticks(49);
        chk("after_ign_rise", piranha_state, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
